adsr_multi: RTL

- Second-generation ADSR envelope generator for the synth voice path.
- Parametrised envelope width; programmable rate prescaler; optional hold phase.
- Exact clamping at the peak, sustain and floor levels, so the sustain level is never skipped.
- Retriggers attack from the current level. Output feeds the voice amplitude multiplier.

---
 rtl/adsr_multi.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/adsr_multi.sv
// adsr_multi: ADSR envelope generator with rate prescaler, exact clamping and retrigger
// from the current level. Optional hold phase is built when ADSR_HOLD_EN is defined.
module adsr_multi #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [DIV_W-1:0]  div,
  input  logic [WIDTH-1:0]  ai,
  input  logic [WIDTH-1:0]  di,
  input  logic [WIDTH-1:0]  s,
  input  logic [WIDTH-1:0]  ri,
`ifdef ADSR_HOLD_EN
  input  logic [HOLD_W-1:0] hold,
`endif
  output logic [WIDTH-1:0]  envelope,
  output logic [2:0]        phase,
  output logic              active
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StHold    = 3'd2,
    StDecay   = 3'd3,
    StSustain = 3'd4,
    StRelease = 3'd5
  } phase_e;

  localparam logic [WIDTH-1:0] Max = '1;

  phase_e             r_phase;
  logic [WIDTH-1:0]   r_env;
  logic [DIV_W-1:0]   r_presc;
  logic               r_trig_d;
  logic               r_armed;
`ifdef ADSR_HOLD_EN
  logic [HOLD_W-1:0]  r_hold_cnt;
`endif

  logic               w_rise;
  logic               w_tick;
  logic               w_gate_off;
  logic [WIDTH:0]     w_sum;
  logic               w_atk_full;
  logic [WIDTH:0]     w_dec_lim;
  logic               w_dec_floor;
  logic               w_rel_floor;

  // A rise needs trig to have been sampled low since reset, so a gate held
  // high across reset release does not start a note.
  assign w_rise      = trig & ~r_trig_d & r_armed;
  assign w_tick      = (r_presc == div);
  assign w_gate_off  = ~trig & ((r_phase == StAttack) | (r_phase == StHold) |
                                (r_phase == StDecay)  | (r_phase == StSustain));

  assign w_sum       = {1'b0, r_env} + {1'b0, ai};
  assign w_atk_full  = (ai == '0) | (w_sum >= {1'b0, Max});

  // env - di <= s rewritten as env <= s + di so nothing can wrap.
  assign w_dec_lim   = {1'b0, s} + {1'b0, di};
  assign w_dec_floor = (di == '0) | ({1'b0, r_env} <= w_dec_lim);

  assign w_rel_floor = (ri == '0) | (r_env <= ri);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= StIdle;
      r_env      <= '0;
      r_presc    <= '0;
      r_trig_d   <= 1'b0;
      r_armed    <= 1'b0;
`ifdef ADSR_HOLD_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      r_trig_d <= trig;
      if (!trig) begin
        r_armed <= 1'b1;
      end

      if (w_rise || w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end

      if (w_rise) begin
        r_phase <= StAttack;
      end else if (w_gate_off) begin
        r_phase <= StRelease;
      end else begin
        case (r_phase)
          StIdle: begin
            r_env <= '0;
          end
          StAttack: begin
            if (w_tick) begin
              if (w_atk_full) begin
                r_env <= Max;
`ifdef ADSR_HOLD_EN
                if (hold != '0) begin
                  r_phase    <= StHold;
                  r_hold_cnt <= hold;
                end else begin
                  r_phase <= StDecay;
                end
`else
                r_phase <= StDecay;
`endif
              end else begin
                r_env <= w_sum[WIDTH-1:0];
              end
            end
          end
`ifdef ADSR_HOLD_EN
          StHold: begin
            r_env <= Max;
            if (w_tick) begin
              if (r_hold_cnt <= HOLD_W'(1)) begin
                r_phase    <= StDecay;
                r_hold_cnt <= '0;
              end else begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
              end
            end
          end
`endif
          StDecay: begin
            if (w_tick) begin
              if (w_dec_floor) begin
                r_env   <= s;
                r_phase <= StSustain;
              end else begin
                r_env <= r_env - di;
              end
            end
          end
          StSustain: begin
            r_env <= s;
          end
          StRelease: begin
            if (w_tick) begin
              if (w_rel_floor) begin
                r_env   <= '0;
                r_phase <= StIdle;
              end else begin
                r_env <= r_env - ri;
              end
            end
          end
          default: begin
            r_phase <= StIdle;
            r_env   <= '0;
          end
        endcase
      end
    end
  end

  assign envelope = r_env;
  assign phase    = r_phase;
  assign active   = (r_phase != StIdle);

endmodule
